// File: rtl/ats21.sv
// Alarm/timer block: 16 programmable-rate 16-bit clocks and 32 alarm/countdown-timer slots, driven by two clients.
// Latency: a command result appears one cycle after its execute cycle; an expiry is reported one cycle after it occurs.
// Backpressure: ready is low for the whole five-cycle transaction, and req is ignored while ready is low.
module ats21 (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [15:0] ctrlA,
  input  logic [15:0] ctrlB,
  output logic        ready,
  output logic [1:0]  stat,
  output logic [23:0] data
);

  typedef enum logic [2:0] {S_IDLE, S_HI, S_LO, S_EXA, S_EXB} state_t;

  state_t      state_q, state_d;
  logic [15:0] up_a_q, up_b_q, lo_a_q, lo_b_q;

  // FSM outputs: which client executes this cycle and its instruction halves
  logic        exec, cli;
  logic [15:0] cu, cl;

  // Global mode
  logic        active_q, active_d;
  logic        as_a_q, as_a_d, as_b_q, as_b_d;   // allow-slot per client
  logic        ac_a_q, ac_a_d, ac_b_q, ac_b_d;   // allow-clock per client
  logic [2:0]  p_q;

  // Clocks
  logic [15:0] cnt_q  [16];
  logic [15:0] cnt_d  [16];
  logic [15:0] cnt_inc[16];
  logic [1:0]  rate_q [16];
  logic [1:0]  rate_d [16];
  logic [15:0] cen_q, cen_d, tick;

  // Slots
  logic [31:0] sen_q, sen_d, styp_q, styp_d, srpt_q, srpt_d, pend_q, pend_d;
  logic [3:0]  sclk_q [32];
  logic [3:0]  sclk_d [32];
  logic [15:0] sval_q [32];
  logic [15:0] sval_d [32];
  logic [15:0] srem_q [32];
  logic [15:0] srem_d [32];

  // Command decode
  logic [2:0]  op;
  logic [3:0]  clk_id;
  logic [4:0]  slot_id, tgt;
  logic        is_clk_op, is_slot_op, allow_clk, allow_slot, cmd_ok, cmd_res, do_cmd;
  logic        rep_vld, rep_go;
  logic [4:0]  rep_idx;

  logic [1:0]  stat_q, stat_d;
  logic [23:0] data_q, data_d;

  // Bits [5:4] of the upper half carry no meaning for any opcode
  logic        unused_bits;
  assign unused_bits = ^cu[5:4];

  // Transaction state register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Transaction next-state: fixed five-step walk once req is taken
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req) state_d = S_HI;
      S_HI:    state_d = S_LO;
      S_LO:    state_d = S_EXA;
      S_EXA:   state_d = S_EXB;
      S_EXB:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Transaction outputs: ready and the executing client's instruction
  always_comb begin
    ready = (state_q == S_IDLE);
    exec  = 1'b0;
    cli   = 1'b0;
    cu    = up_a_q;
    cl    = lo_a_q;
    case (state_q)
      S_EXA: exec = 1'b1;
      S_EXB: begin
        exec = 1'b1;
        cli  = 1'b1;
        cu   = up_b_q;
        cl   = lo_b_q;
      end
      default: ;
    endcase
  end

  // Capture the upper halves, then the lower halves, of both instructions
  always_ff @(posedge clk) begin
    if (!reset) begin
      up_a_q <= '0;
      up_b_q <= '0;
      lo_a_q <= '0;
      lo_b_q <= '0;
    end else begin
      if (state_q == S_HI) begin
        up_a_q <= ctrlA;
        up_b_q <= ctrlB;
      end
      if (state_q == S_LO) begin
        lo_a_q <= ctrlA;
        lo_b_q <= ctrlB;
      end
    end
  end

  // Decode and permission check of the executing instruction
  always_comb begin
    op         = cu[15:13];
    clk_id     = cu[12:9];
    slot_id    = cu[12:8];
    is_clk_op  = (op == 3'b001) || (op == 3'b010);
    is_slot_op = (op == 3'b101) || (op == 3'b110) || (op == 3'b111);
    allow_clk  = cli ? ac_b_q : ac_a_q;
    allow_slot = cli ? as_b_q : as_a_q;
    cmd_ok     = 1'b1;
    if (op == 3'b100)                                          cmd_ok = 1'b0;
    else if (!active_q && (op != 3'b011) && (op != 3'b000))    cmd_ok = 1'b0;
    else if (is_clk_op && !allow_clk)                          cmd_ok = 1'b0;
    else if (is_slot_op && !allow_slot)                        cmd_ok = 1'b0;
    cmd_res = exec && (op != 3'b000);
    do_cmd  = cmd_res && cmd_ok;
    tgt     = is_clk_op ? {1'b0, clk_id} : (is_slot_op ? slot_id : 5'd0);
  end

  // Clock ticks from the shared prescaler
  always_comb begin
    for (int c = 0; c < 16; c++) begin
      logic r;
      case (rate_q[c])
        2'b00:   r = 1'b1;
        2'b01:   r = p_q[0];
        2'b10:   r = &p_q[1:0];
        default: r = &p_q;
      endcase
      tick[c]    = cen_q[c] && active_q && r;
      cnt_inc[c] = cnt_q[c] + 16'd1;
    end
  end

  // Lowest-numbered pending slot is the one reported next
  always_comb begin
    rep_vld = 1'b0;
    rep_idx = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (pend_q[i]) begin
        rep_vld = 1'b1;
        rep_idx = 5'(i);
      end
    end
    rep_go = rep_vld && !cmd_res;
  end

  // Next state of clocks and slots: ticks and expiries first, then the command overrides
  always_comb begin
    active_d = active_q;
    as_a_d   = as_a_q;
    as_b_d   = as_b_q;
    ac_a_d   = ac_a_q;
    ac_b_d   = ac_b_q;
    cnt_d    = cnt_q;
    rate_d   = rate_q;
    cen_d    = cen_q;
    sen_d    = sen_q;
    styp_d   = styp_q;
    srpt_d   = srpt_q;
    sclk_d   = sclk_q;
    sval_d   = sval_q;
    srem_d   = srem_q;
    pend_d   = pend_q;

    for (int c = 0; c < 16; c++) begin
      if (tick[c]) cnt_d[c] = cnt_inc[c];
    end

    // Clear the reported flag before expiries so a same-cycle expiry keeps it set
    if (rep_go) pend_d[rep_idx] = 1'b0;

    for (int s = 0; s < 32; s++) begin
      if (sen_q[s] && tick[sclk_q[s]]) begin
        if (!styp_q[s]) begin
          if (cnt_inc[sclk_q[s]] == sval_q[s]) begin
            pend_d[s] = 1'b1;
            if (!srpt_q[s]) sen_d[s] = 1'b0;
          end
        end else if (srem_q[s] <= 16'd1) begin
          pend_d[s] = 1'b1;
          sen_d[s]  = 1'b0;
        end else begin
          srem_d[s] = srem_q[s] - 16'd1;
        end
      end
    end

    if (do_cmd) begin
      case (op)
        3'b001: begin
          rate_d[clk_id] = cu[7:6];
          cnt_d[clk_id]  = 16'd0;
        end
        3'b010: cen_d[clk_id] = cu[7];
        3'b011: begin
          active_d = cu[12];
          as_a_d   = cu[11];
          as_b_d   = cu[10];
          ac_a_d   = cu[9];
          ac_b_d   = cu[8];
        end
        3'b101: begin
          styp_d[slot_id] = 1'b0;
          srpt_d[slot_id] = cu[7];
          sclk_d[slot_id] = cu[3:0];
          sval_d[slot_id] = cl;
          sen_d[slot_id]  = 1'b0;
        end
        3'b110: begin
          styp_d[slot_id] = 1'b1;
          sclk_d[slot_id] = cu[3:0];
          sval_d[slot_id] = cl;
          sen_d[slot_id]  = 1'b0;
        end
        3'b111: begin
          sen_d[slot_id] = cu[7];
          if (cu[7] && styp_q[slot_id]) srem_d[slot_id] = sval_q[slot_id];
        end
        default: ;
      endcase
    end
  end

  // Report mux: a command result takes the slot, otherwise an expiry, otherwise nothing
  always_comb begin
    stat_d = 2'b00;
    data_d = 24'd0;
    if (cmd_res) begin
      stat_d = do_cmd ? 2'b10 : 2'b11;
      data_d = {cli, op, tgt, 15'd0};
    end else if (rep_vld) begin
      stat_d = 2'b01;
      data_d = {2'b00, styp_q[rep_idx], rep_idx, cnt_q[sclk_q[rep_idx]]};
    end
  end

  // Mode, clock, slot and report registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      p_q      <= '0;
      active_q <= 1'b1;
      as_a_q   <= 1'b1;
      as_b_q   <= 1'b1;
      ac_a_q   <= 1'b1;
      ac_b_q   <= 1'b1;
      cen_q    <= '0;
      sen_q    <= '0;
      styp_q   <= '0;
      srpt_q   <= '0;
      pend_q   <= '0;
      stat_q   <= 2'b00;
      data_q   <= '0;
      for (int c = 0; c < 16; c++) begin
        cnt_q[c]  <= '0;
        rate_q[c] <= '0;
      end
      for (int s = 0; s < 32; s++) begin
        sclk_q[s] <= '0;
        sval_q[s] <= '0;
        srem_q[s] <= '0;
      end
    end else begin
      p_q      <= p_q + 3'd1;
      active_q <= active_d;
      as_a_q   <= as_a_d;
      as_b_q   <= as_b_d;
      ac_a_q   <= ac_a_d;
      ac_b_q   <= ac_b_d;
      cen_q    <= cen_d;
      sen_q    <= sen_d;
      styp_q   <= styp_d;
      srpt_q   <= srpt_d;
      pend_q   <= pend_d;
      stat_q   <= stat_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      rate_q   <= rate_d;
      sclk_q   <= sclk_d;
      sval_q   <= sval_d;
      srem_q   <= srem_d;
    end
  end

  assign stat = stat_q;
  assign data = data_q;

endmodule

// File: tb/tb_ats21.sv
// Directed bench for ats21: expected reports are queued as stimulus is driven and matched in order.
module tb_ats21;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic [15:0] ctrlA, ctrlB;
  logic        ready;
  logic [1:0]  stat;
  logic [23:0] data;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [1:0]  st;
    logic [23:0] dat;
  } exp_t;

  exp_t q[$];

  ats21 dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .ctrlA (ctrlA),
    .ctrlB (ctrlB),
    .ready (ready),
    .stat  (stat),
    .data  (data)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Every non-idle report must match the oldest queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && stat !== 2'b00) begin
      checks++;
      assert (q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_out observed stat=%b data=%h expected no report", stat, data);
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        assert ({stat, data} === {e.st, e.dat}) else begin
          errors++;
          $error("FAIL report observed stat=%b data=%h expected stat=%b data=%h", stat, data, e.st, e.dat);
        end
      end
    end
  end

  task automatic push(input logic [1:0] s, input logic [23:0] d);
    exp_t e;
    e.st  = s;
    e.dat = d;
    q.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One transaction; hold keeps req high through the busy cycles
  task automatic txn(input string tag, input logic [15:0] au, input logic [15:0] al,
                     input logic [15:0] bu, input logic [15:0] bl, input bit hold);
    int n = 0;
    while (ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_ready_in"}, {31'd0, ready}, 32'd1);
    req = 1'b1; ctrlA = au; ctrlB = bu;
    @(posedge clk); #1;
    chk({tag, "_busy"}, {31'd0, ready}, 32'd0);
    req = hold;
    @(posedge clk); #1;
    ctrlA = al; ctrlB = bl;
    @(posedge clk); #1;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_ready_out"}, {31'd0, ready}, 32'd1);
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk); #1;
    checks++;
    assert (q.size() == 0) else begin
      errors++;
      $error("FAIL %s_drain observed pending=%0d expected 0", tag, q.size());
      q.delete();
    end
  endtask

  initial begin
    reset = 1'b0; req = 1'b0; ctrlA = '0; ctrlB = '0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_stat",  {30'd0, stat},  32'd0);
    chk("rst_data",  {8'd0, data},   32'd0);
    reset = 1'b1;
    mon_en = 1'b1;

    // Set clk0 rate 00 (A) and clk1 rate 01 (B)
    push(2'b10, 24'h100000);
    push(2'b10, 24'h908000);
    txn("setclk", 16'h2000, 16'h0000, 16'h2240, 16'h0000, 1'b0);
    drain("setclk", 10);

    // Alarm slot 3 on clk0, compare 5, then enable it
    push(2'b10, 24'h518000);
    push(2'b10, 24'hF18000);
    txn("alarm", 16'hA300, 16'h0005, 16'hE380, 16'h0000, 1'b0);
    drain("alarm", 10);

    // Enable clk0: one alarm report at count 5
    push(2'b10, 24'h200000);
    push(2'b01, 24'h030005);
    txn("en_clk0", 16'h4080, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    drain("alarm_evt", 50);

    // Clear clk0: count passes 5 again, non-repeating alarm must stay silent
    push(2'b10, 24'h100000);
    txn("clr_clk0", 16'h2000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    repeat (20) @(posedge clk);
    drain("no_rearm", 1);

    // Timer slot 2 on clk1 interval 3, enabled; then start clk1
    push(2'b10, 24'h610000);
    push(2'b10, 24'hF10000);
    txn("timer", 16'hC201, 16'h0003, 16'hE280, 16'h0000, 1'b0);
    drain("timer", 10);
    push(2'b10, 24'h208000);
    push(2'b01, 24'h220003);
    txn("en_clk1", 16'h4380, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    drain("timer_evt", 50);

    // Withdraw A's slot permission: A's alarm rejected, B's accepted
    push(2'b10, 24'h300000);
    txn("mode_a", 16'h7700, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    push(2'b11, 24'h518000);
    push(2'b10, 24'hD18000);
    txn("perm", 16'hA300, 16'h0005, 16'hA300, 16'h0005, 1'b0);
    drain("perm", 10);

    // Inactive mode rejects a clock op
    push(2'b10, 24'h300000);
    push(2'b11, 24'h900000);
    txn("inactive", 16'h6F00, 16'h0000, 16'h2000, 16'h0000, 1'b0);
    drain("inactive", 10);

    // Invalid opcode from B while req is held high during the busy cycles
    push(2'b10, 24'h300000);
    push(2'b11, 24'hC00000);
    txn("invalid", 16'h7F00, 16'h0000, 16'h8000, 16'h0000, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("req_ignored", {31'd0, ready}, 32'd1);
    drain("invalid", 10);

    // Reset while capturing the upper halves aborts the transaction
    req = 1'b1; ctrlA = 16'h2000; ctrlB = 16'h2000;
    @(posedge clk); #1;
    chk("hi_busy", {31'd0, ready}, 32'd0);
    reset = 1'b0; req = 1'b0;
    @(posedge clk); #1;
    chk("hi_rst_ready", {31'd0, ready}, 32'd1);
    chk("hi_rst_stat",  {30'd0, stat},  32'd0);
    chk("hi_rst_data",  {8'd0, data},   32'd0);
    reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("hi_rst_idle", {31'd0, ready}, 32'd1);
    drain("end", 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
